dw_minmax_frame_ctrl: RTL and testbench
=======================================

Name: dw_minmax_frame_ctrl

Overview:
- Sequential controller that time-shares one 2-input min/max compare datapath to reduce a frame of up to MAX_LEN words to a single minimum or maximum, plus the index of the winning word.
- Sits between a streaming producer (valid/ready) and a result consumer (valid/ready).
- Mode (signed/unsigned, min/max) and frame length are captured at start and held for the whole frame.

Parameters:
- WIDTH, 8, data word width in bits.
- MAX_LEN, 256, maximum frame length in words; must be ≥ 2.
- LEN_W, $clog2(MAX_LEN+1), width of the len port.
- IDX_W, $clog2(MAX_LEN), width of the index output.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request; accepted only in IDLE
- tc  in  1  1 = two's-complement compare, 0 = unsigned; sampled on start
- max  in  1  1 = maximum, 0 = minimum; sampled on start
- len  in  LEN_W  frame length in words (0..MAX_LEN); sampled on start
- in_valid  in  1  input word valid
- in_data  in  WIDTH  input word
- in_ready  out  1  controller accepts in_data this cycle
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_val  out  WIDTH  reduced min/max value
- out_idx  out  IDX_W  index of the winning word within the frame (0-based)
- out_empty  out  1  frame had len = 0; out_val and out_idx are 0
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n = 0): state = IDLE; in_ready, out_valid, out_empty and busy = 0; out_val and out_idx = 0; the word counter and the latched mode/len are cleared.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On start = 1, latch tc, max and len, and clear the counter.
  - If len = 0, go to DONE with out_empty = 1. Otherwise go to ACCUM.
  - start in any other state is ignored (no queuing).
- ACCUM:
  - in_ready = 1. A beat is transferred when in_valid && in_ready.
  - Beat 0 loads the accumulator directly with in_data, and idx = 0.
  - Each later beat k compares in_data against the accumulator under the latched tc/max.
  - The accumulator is replaced only on strict improvement (in_data < acc for min, > for max). Ties keep the earlier index.
  - When the beat with counter = len−1 transfers, go to DONE on the next edge. in_ready drops in that same next cycle.
- DONE:
  - out_valid = 1; out_val, out_idx and out_empty are held stable until out_valid && out_ready.
  - After acceptance, return to IDLE. out_valid deasserts the cycle after acceptance.
- Latency:
  - Result is valid 1 cycle after the last input beat.
  - Minimum frame time is len + 2 cycles (start → IDLE exit, len beats, DONE) with no stalls.
- Compare rules:
  - Signed compare uses the inverted MSB on both operands. No arithmetic widening is required.
  - Example: tc = 1, 0x80 (−128) < 0x7F (127).
- Boundary conditions:
  - len = 1: the single word is the result, with idx = 0.
  - len = MAX_LEN: the counter reaches MAX_LEN−1 and does not wrap within the frame.
  - Producer stalls (in_valid = 0) in ACCUM: hold all state.
  - Consumer stalls (out_ready = 0) in DONE: hold the result indefinitely.
  - rst_n asserted mid-frame: the frame is discarded and the block returns immediately to reset values.
  - tc, max or len changing mid-frame: no effect.

Optional Feature:
- Macro: DW_MINMAX_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort = 1 in ACCUM or DONE forces IDLE on the next edge with no out_valid pulse; accumulator and counter are cleared.
  - abort in IDLE has no effect.
  - abort and start in the same IDLE cycle: start wins.
- Undefined: the port does not exist, and frames always run to completion.

Decomposition:
- Package dw_minmax_frame_pkg holds:
  - state enum (IDLE = 2'd0, ACCUM = 2'd1, DONE = 2'd2);
  - function better(a, b, tc, max) returning 1 when a strictly beats b.
- Sub-module dw_minmax_cmp2: combinational 2-input signed/unsigned compare producing the better flag. It is instantiated once and shared across beats; it is the time-shared datapath.
- The controller holds the FSM, counter, accumulator, index register and handshakes.

Test Plan:
- Unsigned max: tc = 0, max = 1, len = 4, data 0x10, 0xF0, 0x05, 0xF0 → out_val = 0xF0, out_idx = 1 (tie keeps first), out_valid 1 cycle after beat 3.
- Signed min: tc = 1, max = 0, len = 3, data 0x7F, 0x80, 0x00 → out_val = 0x80, out_idx = 1. The same data with tc = 0 → out_val = 0x00, out_idx = 2.
- Empty and single frames: len = 0 → DONE next cycle, out_empty = 1, out_val = 0. len = 1, data 0xAA → out_val = 0xAA, out_idx = 0, out_empty = 0.
- Backpressure: len = 8 with random in_valid gaps, and out_ready held 0 for 5 cycles in DONE → result stable throughout, in_ready = 0 while in DONE, and start pulses in ACCUM/DONE are ignored.
- Reset mid-frame: rst_n = 0 after beat 2 of len = 6 → all outputs 0 immediately. A new frame of len = 2 (0x03, 0x09), max = 1 → 0x09, idx = 1.
- With DW_MINMAX_ABORT_EN: abort at beat 3 of len = 10 → IDLE next cycle, no out_valid. The following frame len = 2 (0x01, 0x02), max = 0 → 0x01, idx = 0.

Source files
------------

// File: rtl/dw_minmax_frame_pkg.sv
// Shared types and compare helper for the min/max frame reducer.
// Contents:
//   state_e - controller FSM states (IDLE, ACCUM, DONE)
//   CmpW    - operand width seen by better(); callers MSB-align narrower words
//   better  - 1 when operand a strictly beats operand b under tc/max
package dw_minmax_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned CmpW = 64;

  // Operands must be MSB-aligned in CmpW bits so bit CmpW-1 is the sign bit.
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic better(input logic [CmpW-1:0] a, input logic [CmpW-1:0] b,
                                  input logic tc, input logic max);
    logic [CmpW-1:0] ak;
    logic [CmpW-1:0] bk;
    ak = a;
    bk = b;
    ak[CmpW-1] = a[CmpW-1] ^ tc;
    bk[CmpW-1] = b[CmpW-1] ^ tc;
    return max ? (ak > bk) : (ak < bk);
  endfunction

endpackage

// File: rtl/dw_minmax_cmp2.sv
// Combinational 2-input signed/unsigned min/max compare; the single shared
// datapath used on every beat of a frame.
// Ports:
//   a, b     - operands (WIDTH bits)
//   tc       - 1 = two's-complement compare, 0 = unsigned
//   max      - 1 = larger wins, 0 = smaller wins
//   a_better - 1 when a strictly beats b (ties report 0)
module dw_minmax_cmp2
  import dw_minmax_frame_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             tc,
  input  logic             max,
  output logic             a_better
);

  localparam int unsigned Shift = CmpW - WIDTH;

  logic [CmpW-1:0] a_al;
  logic [CmpW-1:0] b_al;

  // Left-align so the word's MSB lands on the helper's sign bit.
  assign a_al = CmpW'(a) << Shift;
  assign b_al = CmpW'(b) << Shift;

  assign a_better = better(a_al, b_al, tc, max);

endmodule

// File: rtl/dw_minmax_frame_ctrl.sv
// Frame min/max reducer: accepts a frame of len words on a valid/ready stream,
// reduces it through one shared comparator, and presents the winning value and
// its 0-based index on a valid/ready result port.
// Optional feature macro: DW_MINMAX_ABORT_EN adds an abort input that drops an
// in-flight frame (ACCUM or DONE) back to IDLE without a result.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   start, tc, max, len   - frame request and mode, sampled in IDLE on start
//   in_valid/in_data/in_ready - input word stream
//   out_valid/out_ready   - result handshake
//   out_val/out_idx/out_empty - result value, winner index, empty-frame flag
//   busy                  - controller not in IDLE
//   abort                 - (DW_MINMAX_ABORT_EN only) discard the current frame
module dw_minmax_frame_ctrl
  import dw_minmax_frame_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned IDX_W   = $clog2(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             tc,
  input  logic             max,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
`ifdef DW_MINMAX_ABORT_EN
  input  logic             abort,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_val,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_empty,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             tc_q, max_q;
  logic [LEN_W-1:0] len_q;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] acc_q;
  logic             empty_q;

  logic             beat;
  logic             last;
  logic             take;
  logic             a_better;
  logic             abort_hit;

`ifdef DW_MINMAX_ABORT_EN
  assign abort_hit = abort && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign beat = (state_q == ACCUM) && in_valid;
  // len_q >= 1 whenever ACCUM is entered, so the subtraction cannot underflow.
  assign last = (LEN_W'(cnt_q) == (len_q - LEN_W'(1)));

  dw_minmax_cmp2 #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a        (in_data),
    .b        (acc_q),
    .tc       (tc_q),
    .max      (max_q),
    .a_better (a_better)
  );

  // Beat 0 seeds the accumulator; later beats replace it only on strict improvement.
  assign take = (cnt_q == '0) || a_better;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (beat && last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc_q    <= 1'b0;
      max_q   <= 1'b0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      empty_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      tc_q    <= tc;
      max_q   <= max;
      len_q   <= len;
      cnt_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      empty_q <= (len == '0);
    end else if (abort_hit) begin
      cnt_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
    end else if (beat) begin
      if (take) begin
        acc_q <= in_data;
        idx_q <= cnt_q;
      end
      // Hold on the final beat so a MAX_LEN frame never wraps the counter.
      if (!last) cnt_q <= cnt_q + IDX_W'(1);
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_val   = acc_q;
  assign out_idx   = idx_q;
  assign out_empty = empty_q;

endmodule

// File: tb/tb_dw_minmax_frame_ctrl.sv
module tb_dw_minmax_frame_ctrl;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MAX_LEN = 256;
  localparam int unsigned LEN_W   = 9;
  localparam int unsigned IDX_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             tc;
  logic             max;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_val;
  logic [IDX_W-1:0] out_idx;
  logic             out_empty;
  logic             busy;
`ifdef DW_MINMAX_ABORT_EN
  logic             abort;
`endif

  dw_minmax_frame_ctrl #(
    .WIDTH   (WIDTH),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W),
    .IDX_W   (IDX_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tc        (tc),
    .max       (max),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef DW_MINMAX_ABORT_EN
    .abort     (abort),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_val   (out_val),
    .out_idx   (out_idx),
    .out_empty (out_empty),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] i;
    logic       e;
  } res_t;

  // data: word j sits in bits [8*j +: 8] (word 0 is the low byte)
  typedef struct packed {
    logic        tc;
    logic        mx;
    logic [8:0]  n;
    logic [63:0] data;
    logic [7:0]  ev;
    logic [7:0]  ei;
    logic        ee;
  } vec_t;

  res_t       sbq[$];
  logic [7:0] dbuf[MAX_LEN];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference reduction written with native signed/unsigned operators.
  function automatic res_t model(input logic tcv, input logic mxv, input int n);
    res_t r;
    logic up;
    r = '0;
    if (n == 0) begin
      r.e = 1'b1;
      return r;
    end
    r.v = dbuf[0];
    for (int k = 1; k < n; k++) begin
      if (tcv) up = mxv ? ($signed(dbuf[k]) > $signed(r.v)) : ($signed(dbuf[k]) < $signed(r.v));
      else     up = mxv ? (dbuf[k] > r.v) : (dbuf[k] < r.v);
      if (up) begin
        r.v = dbuf[k];
        r.i = 8'(k);
      end
    end
    return r;
  endfunction

  task automatic run_frame(input logic tcv, input logic mxv, input int n, input res_t exp,
                           input bit gaps, input int stall);
    res_t r;
    int   i;
    int   guard;
    @(negedge clk);
    start = 1'b1;
    tc    = tcv;
    max   = mxv;
    len   = 9'(n);
    sbq.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'(1));
    i = 0;
    guard = 0;
    while (i < n && guard < 4000) begin
      // Mode and length inputs wander mid-frame; the latched copies must rule.
      tc  = ~tcv;
      max = ~mxv;
      len = 9'($urandom_range(0, 256));
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        start    = 1'b1;
      end else begin
        in_valid = 1'b1;
        in_data  = dbuf[i];
        check("in_ready_beat", 32'(in_ready), 32'(1));
        i++;
      end
      @(negedge clk);
      start = 1'b0;
      guard++;
    end
    check("beat_count", 32'(i), 32'(n));
    in_valid = 1'b0;
    check("out_valid_latency", 32'(out_valid), 32'(1));
    check("in_ready_done", 32'(in_ready), 32'(0));
    for (int s = 0; s < stall; s++) begin
      check("stall_val", 32'(out_val), 32'(exp.v));
      check("stall_idx", 32'(out_idx), 32'(exp.i));
      check("stall_valid", 32'(out_valid), 32'(1));
      check("stall_in_ready", 32'(in_ready), 32'(0));
      start = 1'b1;
      len   = 9'd0;
      @(negedge clk);
      start = 1'b0;
    end
    out_ready = 1'b1;
    r = sbq.pop_front();
    check("out_valid", 32'(out_valid), 32'(1));
    check("out_val", 32'(out_val), 32'(r.v));
    check("out_idx", 32'(out_idx), 32'(r.i));
    check("out_empty", 32'(out_empty), 32'(r.e));
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 32'(out_valid), 32'(0));
    check("busy_idle", 32'(busy), 32'(0));
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_in_ready"}, 32'(in_ready), 32'(0));
    check({nm, "_out_valid"}, 32'(out_valid), 32'(0));
    check({nm, "_busy"}, 32'(busy), 32'(0));
    check({nm, "_out_val"}, 32'(out_val), 32'(0));
    check({nm, "_out_idx"}, 32'(out_idx), 32'(0));
    check({nm, "_out_empty"}, 32'(out_empty), 32'(0));
  endtask

  vec_t tbl[7];
  res_t ex;

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    tc        = 1'b0;
    max       = 1'b0;
    len       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef DW_MINMAX_ABORT_EN
    abort     = 1'b0;
`endif

    tbl[0] = '{tc: 0, mx: 1, n: 4, data: 64'h0000_0000_F005_F010, ev: 8'hF0, ei: 1, ee: 0};
    tbl[1] = '{tc: 1, mx: 0, n: 3, data: 64'h0000_0000_0000_807F, ev: 8'h80, ei: 1, ee: 0};
    tbl[2] = '{tc: 0, mx: 0, n: 3, data: 64'h0000_0000_0000_807F, ev: 8'h00, ei: 2, ee: 0};
    tbl[3] = '{tc: 0, mx: 1, n: 0, data: 64'h0000_0000_0000_0000, ev: 8'h00, ei: 0, ee: 1};
    tbl[4] = '{tc: 0, mx: 0, n: 1, data: 64'h0000_0000_0000_00AA, ev: 8'hAA, ei: 0, ee: 0};
    tbl[5] = '{tc: 1, mx: 1, n: 5, data: 64'h0000_007F_7F01_FF80, ev: 8'h7F, ei: 3, ee: 0};
    tbl[6] = '{tc: 0, mx: 0, n: 4, data: 64'h0000_0000_3333_3333, ev: 8'h33, ei: 0, ee: 0};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 7; k++) begin
      for (int j = 0; j < 8; j++) dbuf[j] = tbl[k].data[j*8 +: 8];
      ex = '{v: tbl[k].ev, i: tbl[k].ei, e: tbl[k].ee};
      run_frame(tbl[k].tc, tbl[k].mx, int'(tbl[k].n), ex, 1'b0, int'($urandom_range(0, 2)));
    end

    // Backpressure: producer gaps plus a 5-cycle consumer stall.
    for (int j = 0; j < 8; j++) dbuf[j] = 8'($urandom);
    run_frame(1'b1, 1'b1, 8, model(1'b1, 1'b1, 8), 1'b1, 5);
    for (int j = 0; j < 8; j++) dbuf[j] = 8'($urandom);
    run_frame(1'b0, 1'b0, 8, model(1'b0, 1'b0, 8), 1'b1, 5);

    // Full-length frames exercise the counter at MAX_LEN-1.
    for (int j = 0; j < MAX_LEN; j++) dbuf[j] = 8'($urandom);
    run_frame(1'b0, 1'b1, MAX_LEN, model(1'b0, 1'b1, MAX_LEN), 1'b0, 1);
    for (int j = 0; j < MAX_LEN; j++) dbuf[j] = 8'($urandom);
    dbuf[MAX_LEN-1] = 8'h80;
    run_frame(1'b1, 1'b0, MAX_LEN, model(1'b1, 1'b0, MAX_LEN), 1'b1, 0);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    start = 1'b1;
    tc    = 1'b0;
    max   = 1'b1;
    len   = 9'd6;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h40;
    @(negedge clk);
    in_data  = 8'h50;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n   = 1'b1;
    dbuf[0] = 8'h03;
    dbuf[1] = 8'h09;
    run_frame(1'b0, 1'b1, 2, '{v: 8'h09, i: 8'd1, e: 1'b0}, 1'b0, 0);

`ifdef DW_MINMAX_ABORT_EN
    @(negedge clk);
    start = 1'b1;
    tc    = 1'b0;
    max   = 1'b1;
    len   = 9'd10;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_data = 8'(j + 1);
      @(negedge clk);
    end
    in_data = 8'h77;
    abort   = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_in_ready", 32'(in_ready), 32'(0));
    for (int j = 0; j < 3; j++) begin
      check("abort_no_valid", 32'(out_valid), 32'(0));
      @(negedge clk);
    end
    dbuf[0] = 8'h01;
    dbuf[1] = 8'h02;
    run_frame(1'b0, 1'b0, 2, '{v: 8'h01, i: 8'd0, e: 1'b0}, 1'b0, 0);
`endif

    check("scoreboard_drained", 32'(sbq.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
